// File: rtl/k6502_int_ctrl.sv
// Interrupt controller for the k6502 core: synchronises NMI and NUM_IRQ IRQ lines,
// edge-detects NMI and arbitrates reset > NMI > IRQ at instruction boundaries.
module k6502_int_ctrl #(
  parameter int          NUM_IRQ = 4,
  parameter logic [7:0]  VEC_RST = 8'hFC,
  parameter logic [7:0]  VEC_NMI = 8'hFA,
  parameter logic [7:0]  VEC_IRQ = 8'hFE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sync,
  input  logic               nmi_n,
  input  logic [NUM_IRQ-1:0] irq_n,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               i_flag,
  input  logic               vec_ack,
  output logic               take_rst,
  output logic               take_nmi,
  output logic               take_irq,
  output logic [7:0]         vec_lo,
  output logic [2:0]         irq_src,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               busy
);

  // One-hot state maps bit-for-bit onto {take_irq, take_nmi, take_rst}.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_RESET = 3'b001,
    ST_NMI   = 3'b010,
    ST_IRQ   = 3'b100
  } state_e;

  state_e             state_q, state_d;
  logic               nmi_s1_q, nmi_s2_q, nmi_prev_q;
  logic [NUM_IRQ-1:0] irq_s1_q, irq_s2_q;
  logic               nmi_pend_q, nmi_pend_d;
  logic [2:0]         irq_src_q, irq_src_d;
  logic [2:0]         irq_win;
  logic [NUM_IRQ-1:0] irq_active;
  logic               nmi_fall;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two synchroniser stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_s1_q   <= 1'b1;
      nmi_s2_q   <= 1'b1;
      nmi_prev_q <= 1'b1;
      irq_s1_q   <= '1;
      irq_s2_q   <= '1;
    end else begin
      nmi_s1_q   <= nmi_n;
      nmi_s2_q   <= nmi_s1_q;
      nmi_prev_q <= nmi_s2_q;
      irq_s1_q   <= irq_n;
      irq_s2_q   <= irq_s1_q;
    end
  end

  assign irq_pending = ~irq_s2_q;
  assign irq_active  = irq_pending & irq_mask;
  assign nmi_fall    = nmi_prev_q & ~nmi_s2_q;

  // NOTE: every combinational output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    nmi_pend_d = nmi_pend_q;
    if ((state_q == ST_NMI) && vec_ack) nmi_pend_d = 1'b0;
    // A fresh edge in the acknowledge cycle must not be lost.
    if (nmi_fall) nmi_pend_d = 1'b1;
  end

  always_comb begin
    irq_win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_active[i]) irq_win = 3'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    irq_src_d = irq_src_q;
    case (state_q)
      ST_RESET, ST_NMI, ST_IRQ: begin
        if (vec_ack) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (sync) begin
          if (nmi_pend_q) begin
            state_d = ST_NMI;
          end else if ((|irq_active) && !i_flag) begin
            state_d   = ST_IRQ;
            irq_src_d = irq_win;
          end
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // NOTE: only control state is reset; there is no storage array here to exempt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RESET;
      nmi_pend_q <= 1'b0;
      irq_src_q  <= '0;
    end else begin
      state_q    <= state_d;
      nmi_pend_q <= nmi_pend_d;
      irq_src_q  <= irq_src_d;
    end
  end

  assign take_rst = state_q[0];
  assign take_nmi = state_q[1];
  assign take_irq = state_q[2];
  assign busy     = |state_q;
  assign irq_src  = irq_src_q;

  always_comb begin
    case (state_q)
      ST_RESET: vec_lo = VEC_RST;
      ST_NMI:   vec_lo = VEC_NMI;
      default:  vec_lo = VEC_IRQ;
    endcase
  end

endmodule

// File: tb/tb_k6502_int_ctrl.sv
// Directed bench for k6502_int_ctrl: expectations are queued with the stimulus
// and compared against the DUT outputs after the clock edges that produce them.
module tb_k6502_int_ctrl;

  localparam logic [2:0] T_IDLE = 3'b000;
  localparam logic [2:0] T_RST  = 3'b001;
  localparam logic [2:0] T_NMI  = 3'b010;
  localparam logic [2:0] T_IRQ  = 3'b100;

  logic       clk = 1'b0;
  logic       rst, sync, nmi_n, i_flag, vec_ack;
  logic [3:0] irq_n, irq_mask;
  logic       take_rst, take_nmi, take_irq, busy;
  logic [7:0] vec_lo;
  logic [2:0] irq_src;
  logic [3:0] irq_pending;

  typedef struct {
    string      tag;
    logic [2:0] take;
    logic [7:0] vec;
    logic [2:0] src;
    logic [3:0] pend;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  k6502_int_ctrl #(.NUM_IRQ(4)) dut (
    .clk(clk), .rst(rst), .sync(sync), .nmi_n(nmi_n), .irq_n(irq_n),
    .irq_mask(irq_mask), .i_flag(i_flag), .vec_ack(vec_ack),
    .take_rst(take_rst), .take_nmi(take_nmi), .take_irq(take_irq),
    .vec_lo(vec_lo), .irq_src(irq_src), .irq_pending(irq_pending), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input string tag, input logic [2:0] take,
                          input logic [2:0] src, input logic [3:0] pend);
    exp_t e;
    e.tag  = tag;
    e.take = take;
    e.vec  = (take == T_RST) ? 8'hFC : (take == T_NMI) ? 8'hFA : 8'hFE;
    e.src  = src;
    e.pend = pend;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [18:0] obs, req;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: observed empty queue, expected an entry");
    end else begin
      e   = sb_q.pop_front();
      obs = {take_irq, take_nmi, take_rst, busy, vec_lo, irq_src, irq_pending};
      req = {e.take, |e.take, e.vec, e.src, e.pend};
      assert (obs === req) else begin
        errors++;
        $error("FAIL %s: observed take=%b busy=%b vec=%h src=%0d pend=%b, expected take=%b busy=%b vec=%h src=%0d pend=%b",
               e.tag, obs[18:16], obs[15], obs[14:7], obs[6:4], obs[3:0],
               req[18:16], req[15], req[14:7], req[6:4], req[3:0]);
      end
    end
  endtask

  task automatic step(input int n, input string tag, input logic [2:0] take,
                      input logic [2:0] src, input logic [3:0] pend);
    push_exp(tag, take, src, pend);
    tick(n);
    check_out();
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0; nmi_n = 1'b1; i_flag = 1'b0; vec_ack = 1'b0;
    irq_n = 4'hF; irq_mask = 4'h0;

    // Reset state, sync ignored in RESET_SEQ, exit on vec_ack
    step(2, "reset_hold", T_RST, 3'd0, 4'h0);
    rst = 1'b0; sync = 1'b1;
    step(2, "reset_sync_ignored", T_RST, 3'd0, 4'h0);
    vec_ack = 1'b1;
    step(1, "reset_exit", T_IDLE, 3'd0, 4'h0);
    vec_ack = 1'b0; sync = 1'b0;

    // Asynchronous reset mid-cycle
    #3 rst = 1'b1;
    push_exp("reset_async", T_RST, 3'd0, 4'h0);
    #1 check_out();
    tick(1);
    rst = 1'b0; vec_ack = 1'b1;
    step(1, "reset_async_exit", T_IDLE, 3'd0, 4'h0);

    // Stray acknowledge in IDLE
    step(2, "stray_ack", T_IDLE, 3'd0, 4'h0);
    vec_ack = 1'b0;

    // NMI latency, exit, held-low single trigger
    sync = 1'b1; nmi_n = 1'b0;
    step(3, "nmi_early", T_IDLE, 3'd0, 4'h0);
    step(1, "nmi_take", T_NMI, 3'd0, 4'h0);
    vec_ack = 1'b1;
    step(1, "nmi_exit", T_IDLE, 3'd0, 4'h0);
    vec_ack = 1'b0;
    step(5, "nmi_held_once", T_IDLE, 3'd0, 4'h0);
    nmi_n = 1'b1; sync = 1'b0;
    tick(3);

    // IRQ arbitration
    irq_mask = 4'b1010; irq_n = 4'b0101;
    step(2, "irq_pending", T_IDLE, 3'd0, 4'b1010);
    sync = 1'b1;
    step(1, "irq_arb_src1", T_IRQ, 3'd1, 4'b1010);
    sync = 1'b0; vec_ack = 1'b1;
    step(1, "irq_exit1", T_IDLE, 3'd1, 4'b1010);
    vec_ack = 1'b0; irq_mask = 4'b1000; sync = 1'b1;
    step(1, "irq_arb_src3", T_IRQ, 3'd3, 4'b1010);
    sync = 1'b0; vec_ack = 1'b1;
    step(1, "irq_src_hold", T_IDLE, 3'd3, 4'b1010);
    vec_ack = 1'b0; irq_n = 4'hF;
    tick(2);

    // I flag blocking, then release; withdrawal does not abort
    irq_mask = 4'b0001; irq_n = 4'b1110; i_flag = 1'b1;
    step(2, "iflag_pending", T_IDLE, 3'd3, 4'b0001);
    sync = 1'b1;
    step(10, "iflag_block", T_IDLE, 3'd3, 4'b0001);
    i_flag = 1'b0;
    step(1, "iflag_clear", T_IRQ, 3'd0, 4'b0001);
    sync = 1'b0; irq_n = 4'hF;
    step(3, "irq_withdraw", T_IRQ, 3'd0, 4'b0000);
    vec_ack = 1'b1;
    step(1, "irq_withdraw_exit", T_IDLE, 3'd0, 4'b0000);
    vec_ack = 1'b0;

    // Simultaneous NMI and IRQ channel 2
    irq_mask = 4'b0100; irq_n = 4'b1011; nmi_n = 1'b0;
    step(3, "nv_wait", T_IDLE, 3'd0, 4'b0100);
    sync = 1'b1;
    step(1, "nv_nmi_first", T_NMI, 3'd0, 4'b0100);
    sync = 1'b0; vec_ack = 1'b1;
    step(1, "nv_nmi_exit", T_IDLE, 3'd0, 4'b0100);
    vec_ack = 1'b0; sync = 1'b1;
    step(1, "nv_irq_second", T_IRQ, 3'd2, 4'b0100);
    sync = 1'b0; vec_ack = 1'b1;
    step(1, "nv_irq_exit", T_IDLE, 3'd2, 4'b0100);
    vec_ack = 1'b0; irq_n = 4'hF; nmi_n = 1'b1;
    tick(3);

    // New NMI edge coinciding with the NMI acknowledge
    sync = 1'b1; nmi_n = 1'b0;
    step(4, "edge_ack_take", T_NMI, 3'd2, 4'h0);
    sync = 1'b0; nmi_n = 1'b1;
    tick(3);
    nmi_n = 1'b0;
    tick(2);
    vec_ack = 1'b1;
    step(1, "edge_ack_exit", T_IDLE, 3'd2, 4'h0);
    vec_ack = 1'b0; sync = 1'b1;
    step(1, "edge_ack_retake", T_NMI, 3'd2, 4'h0);
    sync = 1'b0; vec_ack = 1'b1;
    step(1, "edge_ack_final", T_IDLE, 3'd2, 4'h0);
    vec_ack = 1'b0; nmi_n = 1'b1;
    tick(3);

    // Reset during IRQ_SEQ with an NMI pending: NMI must be lost
    irq_mask = 4'b0001; irq_n = 4'b1110;
    tick(2);
    sync = 1'b1;
    step(1, "rmid_irq", T_IRQ, 3'd0, 4'b0001);
    sync = 1'b0; nmi_n = 1'b0;
    step(3, "rmid_nmi_pend", T_IRQ, 3'd0, 4'b0001);
    #3 rst = 1'b1; nmi_n = 1'b1; irq_n = 4'hF;
    push_exp("rmid_reset", T_RST, 3'd0, 4'h0);
    #1 check_out();
    tick(1);
    rst = 1'b0;
    tick(2);
    vec_ack = 1'b1;
    step(1, "rmid_exit", T_IDLE, 3'd0, 4'h0);
    vec_ack = 1'b0; sync = 1'b1;
    step(4, "rmid_no_nmi", T_IDLE, 3'd0, 4'h0);
    sync = 1'b0;

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: observed %0d leftover entries, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/k6502_int_ctrl.md
# k6502_int_ctrl

Parametrised interrupt controller for the k6502 core, the successor to the single-source interrupt sequencer. It synchronises one NMI line and `NUM_IRQ` maskable IRQ lines, edge-detects NMI, arbitrates reset > NMI > IRQ at instruction boundaries, and holds the selected sequence until the microcode acknowledges the vector fetch. Its outputs drive the microcode's interrupt inputs and the low byte of the vector address.

## Interface
- `NUM_IRQ`, 4: number of maskable IRQ channels, legal range 1..8.
- `VEC_RST`, 8'hFC: vector low byte for the reset sequence.
- `VEC_NMI`, 8'hFA: vector low byte for the NMI sequence.
- `VEC_IRQ`, 8'hFE: vector low byte for the IRQ sequence, also used for BRK.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sync`  in  1  high in the cycle where the microcode would fetch the next opcode (instruction boundary).
- `nmi_n`  in  1  asynchronous NMI pin, active-low, falling-edge sensitive.
- `irq_n`  in  NUM_IRQ  asynchronous IRQ pins, active-low, level sensitive.
- `irq_mask`  in  NUM_IRQ  per-channel enable; 1 = enabled.
- `i_flag`  in  1  processor I flag; 1 blocks all IRQs.
- `vec_ack`  in  1  one-cycle pulse from the microcode when the vector high byte has been fetched.
- `take_rst`  out  1  reset sequence active.
- `take_nmi`  out  1  NMI sequence active.
- `take_irq`  out  1  IRQ sequence active.
- `vec_lo`  out  8  vector low byte for the active sequence.
- `irq_src`  out  3  index of the IRQ channel that won arbitration.
- `irq_pending`  out  NUM_IRQ  synchronised, active-high IRQ levels, unmasked.
- `busy`  out  1  any sequence active (OR of the three `take_*` outputs).

## Operation
- **Synchronisers.** Two flops on each of `nmi_n` and `irq_n[i]`. Both stages reset to 1 (inactive). `irq_pending` = inverted second stage.
- **NMI edge detector.** A third flop holds the previous synchronised `nmi_n`. A 1→0 transition sets `nmi_pend`.
  - `nmi_pend` clears on `vec_ack` while in NMI_SEQ.
  - If a new edge arrives in the same cycle as that `vec_ack`, the set wins and `nmi_pend` stays 1.
- **FSM states.** RESET_SEQ, IDLE, NMI_SEQ, IRQ_SEQ. The state is one-hot encoded directly onto `take_rst`, `take_nmi`, `take_irq`; IDLE means all three are 0.
- **RESET_SEQ.** Entered asynchronously by `rst`. Leaves to IDLE on `vec_ack`; `sync` is ignored in this state.
- **IDLE.** Acts only on a cycle where `sync`=1:
  - `nmi_pend`=1 → NMI_SEQ.
  - Otherwise, if `|(irq_pending & irq_mask)` and `i_flag`=0 → IRQ_SEQ. `irq_src` captures the lowest-index active, enabled channel.
  - Otherwise, stay in IDLE.
- **NMI_SEQ / IRQ_SEQ.** Return to IDLE on `vec_ack`. `sync` is ignored in both states.
- **vec_lo.** Combinational from state: RESET_SEQ → `VEC_RST`, NMI_SEQ → `VEC_NMI`, IRQ_SEQ and IDLE → `VEC_IRQ`.
- **irq_src.** Holds its value until the next IRQ_SEQ entry. Upper bits are 0 when `NUM_IRQ` < 8.
- **Stray acknowledges.** `vec_ack` in IDLE is ignored.
- **IRQ withdrawal.** An IRQ line deasserting after IRQ_SEQ entry does not abort the sequence.

## Timing
- **Reset values (while `rst`=1 and after):** state RESET_SEQ, `take_rst`=1, `take_nmi`=0, `take_irq`=0, `busy`=1, `vec_lo`=`VEC_RST`, `irq_src`=0, `irq_pending`=0, `nmi_pend`=0.
- **Reset mid-sequence.** Asserting `rst` during any sequence immediately forces the reset values above; any pending NMI is lost.
- **NMI latency.** `nmi_n` sampled low at edge k → synchronised low after edge k+1 → `nmi_pend`=1 after edge k+2. The earliest `take_nmi`=1 follows the first edge at or after k+3 with `sync`=1.
- **IRQ latency.** `irq_n[i]` sampled low at edge k → `irq_pending[i]`=1 after edge k+1. The earliest `take_irq`=1 follows the next edge with `sync`=1.
- **Sequence exit.** `take_*` falls at the edge that samples `vec_ack`=1.
- **Simultaneous NMI and IRQ.** NMI wins. The IRQ is taken at a later boundary if it is still asserted and still enabled.
- **NMI held low.** A held-low NMI triggers exactly once. A new trigger needs `nmi_n` to go high for at least 2 clocks, then low again.

## Test plan
- **Reset.** Assert `rst` async mid-cycle → `take_rst`=1 and `vec_lo`=8'hFC immediately. Release, pulse `vec_ack` → IDLE, `vec_lo`=8'hFE.
- **NMI.** Drop `nmi_n` at edge k, hold `sync`=1 → `take_nmi`=1 after edge k+3, `vec_lo`=8'hFA. `vec_ack` → IDLE. With `nmi_n` still low and further `sync` pulses, no second NMI.
- **IRQ arbitration.** `irq_n`=4'b0101 (channels 1 and 3 active), `irq_mask`=4'b1010, `i_flag`=0, `sync` → `take_irq`=1, `irq_src`=1. Repeat with `irq_mask`=4'b1000 → `irq_src`=3.
- **IRQ blocking.** `i_flag`=1 with channel 0 asserted and enabled → no `take_irq` across 10 syncs. Clear `i_flag` → taken at the next sync.
- **NMI vs IRQ.** NMI edge and IRQ channel 2 active at the same boundary → `take_nmi` first. After `vec_ack` and the next `sync` → `take_irq` with `irq_src`=2.
- **Edge cases.** NMI edge landing in the same cycle as NMI `vec_ack` → `nmi_pend` stays 1 and NMI is re-taken at the next sync. Assert `rst` during IRQ_SEQ → `take_irq`=0, `take_rst`=1, `nmi_pend`=0.
